// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding and default sizes.
package mult_pkg;

    localparam int NUM_BITS_DEF = 4;
    localparam int TIMEOUT_DEF  = 64;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        LANZA   = 2'd1,
        ESPERA  = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    // Width needed for a counter that must be able to hold the value max_val.
    function automatic int ancho_contador(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin grant: with both requests pending, the one not served last wins.
module arbitro_rr (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_served;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/arbitro_multiplicador.sv
// Shares one handshake-driven signed multiplier between two requesters, with
// round-robin arbitration and a watchdog on the multiplier's completion flag.
//
// state   | meaning
// REPOSO  | idle, arbitrating pending requests
// LANZA   | m_start pulse, watchdog cleared
// ESPERA  | waiting for a rising edge on m_fin or the watchdog limit
// ENTREGA | one-cycle ack to the granted requester
module arbitro_multiplicador
    import mult_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [NUM_BITS-1:0]   op_a0,
    input  logic [NUM_BITS-1:0]   op_b0,
    input  logic [NUM_BITS-1:0]   op_a1,
    input  logic [NUM_BITS-1:0]   op_b1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [2*NUM_BITS-1:0] resultado,
    output logic                  error,
    output logic [NUM_BITS-1:0]   m_multiplicando,
    output logic [NUM_BITS-1:0]   m_multiplicador,
    output logic                  m_start,
    input  logic [2*NUM_BITS-1:0] m_resultado,
    input  logic                  m_fin
);

    localparam int CW = ancho_contador(TIMEOUT);

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic          fin_q;
    logic          g_idx;
    logic          last_served;
    logic          arb_grant;
    logic          arb_valid;

    arbitro_rr u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .grant       (arb_grant),
        .valid       (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado          <= REPOSO;
            cnt             <= '0;
            fin_q           <= 1'b0;
            g_idx           <= 1'b0;
            // "last served = 1" gives requester 0 priority on the first contested grant
            last_served     <= 1'b1;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            m_start         <= 1'b0;
            resultado       <= '0;
            error           <= 1'b0;
            m_multiplicando <= '0;
            m_multiplicador <= '0;
        end else begin
            fin_q   <= m_fin;
            m_start <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (arb_valid) begin
                        g_idx           <= arb_grant;
                        last_served     <= arb_grant;
                        m_multiplicando <= arb_grant ? op_a1 : op_a0;
                        m_multiplicador <= arb_grant ? op_b1 : op_b0;
                        m_start         <= 1'b1;
                        estado          <= LANZA;
                    end
                end
                LANZA: begin
                    cnt    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (m_fin && !fin_q) begin
                        resultado <= m_resultado;
                        error     <= 1'b0;
                        ack0      <= ~g_idx;
                        ack1      <= g_idx;
                        estado    <= ENTREGA;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        resultado <= '0;
                        error     <= 1'b1;
                        ack0      <= ~g_idx;
                        ack1      <= g_idx;
                        estado    <= ENTREGA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ENTREGA: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Scoreboard bench for arbitro_multiplicador with a 6-cycle behavioural multiplier.
module tb_arbitro_multiplicador;

    localparam int NB = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [NB-1:0] op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
    logic          ack0, ack1, error, m_start;
    logic [2*NB-1:0] resultado;
    logic [NB-1:0] m_multiplicando, m_multiplicador;
    logic [2*NB-1:0] m_resultado;
    logic          m_fin;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       err;
    } exp_t;
    exp_t q[$];

    arbitro_multiplicador #(.NUM_BITS(NB), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (req0),
        .req1            (req1),
        .op_a0           (op_a0),
        .op_b0           (op_b0),
        .op_a1           (op_a1),
        .op_b1           (op_b1),
        .ack0            (ack0),
        .ack1            (ack1),
        .resultado       (resultado),
        .error           (error),
        .m_multiplicando (m_multiplicando),
        .m_multiplicador (m_multiplicador),
        .m_start         (m_start),
        .m_resultado     (m_resultado),
        .m_fin           (m_fin)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product and a one-cycle fin 6 cycles after start.
    logic fin_en = 1'b1;
    int   mcnt;
    logic signed [NB-1:0] ma, mb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fin       <= 1'b0;
            m_resultado <= '0;
            mcnt        <= 0;
            ma          <= '0;
            mb          <= '0;
        end else begin
            m_fin <= 1'b0;
            if (m_start) begin
                mcnt <= 6;
                ma   <= m_multiplicando;
                mb   <= m_multiplicador;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1 && fin_en) begin
                    m_fin       <= 1'b1;
                    m_resultado <= 8'(int'(ma) * int'(mb));
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack, checks m_start pulse width.
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        int   got;
        if (!rst) begin
            if (m_start) begin
                vectors++;
                if (start_prev) begin
                    miscompares++;
                    $display("FAIL m_start_width: high for 2+ cycles, required 1");
                end
            end
            start_prev = m_start;
            if (ack0 || ack1) begin
                vectors++;
                got = ack1 ? 1 : 0;
                if (ack0 && ack1) begin
                    miscompares++;
                    $display("FAIL double_ack: ack0=1 ack1=1, required only one");
                end else if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ack: ack%0d with empty scoreboard", got);
                end else begin
                    e = q.pop_front();
                    if (got != e.idx || resultado !== e.res || error !== e.err) begin
                        miscompares++;
                        $display("FAIL ack_result: got ack%0d res=%h err=%b, required ack%0d res=%h err=%b",
                                 got, resultado, error, e.idx, e.res, e.err);
                    end
                end
            end
        end else begin
            start_prev = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int res, input logic err);
        exp_t e;
        e.idx = idx;
        e.res = 8'(res);
        e.err = err;
        q.push_back(e);
    endtask

    task automatic run_req(input int idx, input int a, input int b, input int limit);
        bit got = 1'b0;
        if (idx == 0) begin
            op_a0 = 4'(a); op_b0 = 4'(b); req0 = 1'b1;
        end else begin
            op_a1 = 4'(a); op_b1 = 4'(b); req1 = 1'b1;
        end
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((idx == 0 && ack0) || (idx == 1 && ack1)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_wait: req%0d got no ack within %0d cycles, required ack", idx, limit);
        end
        if (idx == 0) req0 = 1'b0;
        else          req1 = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack0"}, int'(ack0), 0);
        check({tag, "_ack1"}, int'(ack1), 0);
        check({tag, "_m_start"}, int'(m_start), 0);
        check({tag, "_resultado"}, int'(resultado), 0);
        check({tag, "_error"}, int'(error), 0);
        check({tag, "_m_multiplicando"}, int'(m_multiplicando), 0);
        check({tag, "_m_multiplicador"}, int'(m_multiplicador), 0);
    endtask

    task automatic drain(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // single request, -8 x -8, plus grant-to-start latency
        push(0, 8'h40, 1'b0);
        fork
            run_req(0, -8, -8, 40);
            begin
                @(negedge clk);
                check("start_latency", int'(m_start), 1);
            end
        join
        drain("t1");

        // simultaneous requests straight out of reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(0, 8'hFA, 1'b0);
        push(1, 8'h31, 1'b0);
        fork
            run_req(0, 3, -2, 60);
            run_req(1, 7, 7, 60);
        join
        drain("t2");

        // both held for four operations: grants alternate 0,1,0,1
        push(0, 8'h06, 1'b0);
        push(1, 8'hF4, 1'b0);
        push(0, 8'h05, 1'b0);
        push(1, 8'hD6, 1'b0);
        fork
            begin
                run_req(0, 2, 3, 80);
                run_req(0, -5, -1, 80);
            end
            begin
                run_req(1, -3, 4, 80);
                run_req(1, 6, -7, 80);
            end
        join
        drain("t3");

        // multiplier never finishes: timeout with error
        fin_en = 1'b0;
        push(1, 0, 1'b1);
        fork
            run_req(1, 5, 5, TO + 40);
            begin
                int n = 0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (m_start) break;
                end
                for (int i = 0; i < TO + 30; i++) begin
                    @(negedge clk);
                    n++;
                    if (ack1) break;
                end
                check("timeout_latency", n, TO + 2);
            end
        join
        drain("t4");
        fin_en = 1'b1;

        // reset in ESPERA abandons the operation without ack
        op_a0 = 4'd2; op_b0 = 4'd2; req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_start) break;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("mid_rst");
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push(1, 8'h08, 1'b0);
        run_req(1, -1, -8, 40);
        drain("t5");

        // exhaustive signed sweep through requester 0
        for (int a = -8; a <= 7; a++) begin
            for (int b = -8; b <= 7; b++) begin
                push(0, a * b, 1'b0);
                run_req(0, a, b, 40);
            end
        end
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitro_multiplicador.md
ARBITRO_MULTIPLICADOR -- requirements
Module: arbitro_multiplicador

Interface
REQ-001 SHALL have parameter NUM_BITS, default 4, operand width of the shared multiplier.
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles waited for the multiplier's Fin before aborting.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  requester 0/1 request, held high until its ack.
REQ-006 op_a0, op_b0, op_a1, op_b1  input  NUM_BITS each  signed multiplicando/multiplicador per requester.
REQ-007 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-008 resultado  output  2*NUM_BITS  signed product of the last completed operation.
REQ-009 error  output  1  high with ack when the operation timed out.
REQ-010 m_multiplicando, m_multiplicador  output  NUM_BITS each  operands to the shared multiplier.
REQ-011 m_start  output  1  one-cycle start pulse to the multiplier.
REQ-012 m_resultado  input  2*NUM_BITS  multiplier product; m_fin  input  1  multiplier done (rising edge significant).

Function
REQ-013 SHALL implement FSM states REPOSO, LANZA, ESPERA, ENTREGA.
REQ-014 REPOSO: if any req high, grant one, latch its operands into m_multiplicando/m_multiplicador, record grant index, go LANZA; else stay.
REQ-015 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; after reset requester 0 has priority.
REQ-016 LANZA: m_start=1 for exactly this cycle, clear timeout counter, go ESPERA.
REQ-017 ESPERA: on m_fin rising edge (m_fin=1 and registered m_fin=0) capture m_resultado into resultado, error<=0, go ENTREGA.
REQ-018 ESPERA: counter increments each cycle; on reaching TIMEOUT without edge, resultado<=0, error<=1, go ENTREGA.
REQ-019 ENTREGA: ack of granted requester =1 for exactly one cycle, other ack 0, go REPOSO.
REQ-020 Latency: REPOSO-grant to m_start = 1 cycle; m_fin edge to ack = 1 cycle.
REQ-021 req, op_a*, op_b* SHALL be ignored outside REPOSO; operands are stable to the multiplier from grant until next grant.
REQ-022 A requester whose req stays high in the cycle after its ack SHALL be treated as a new request subject to round-robin.
REQ-023 m_fin edges outside ESPERA SHALL be ignored.
REQ-024 resultado and error SHALL hold their value until the next capture.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-026 rst high SHALL force immediately: state REPOSO, ack0=ack1=0, m_start=0, resultado=0, error=0, m_multiplicando=m_multiplicador=0, counter 0, registered m_fin 0, round-robin pointer to requester 0.
REQ-027 rst mid-operation SHALL abandon the operation with no ack; first grant after release follows REQ-014/015.

Structure
REQ-028 State encoding and the default NUM_BITS/TIMEOUT constants SHALL live in shared package mult_pkg.
REQ-029 Round-robin grant logic SHALL be a sub-module arbitro_rr (inputs req0, req1, last-served; output grant index, valid).

Verification (NUM_BITS=4, behavioural multiplier model with 6-cycle latency)
REQ-030 req0 only, op_a0=-8, op_b0=-8 -> m_start 1 cycle after grant, ack0 pulse, resultado=8'h40, error=0.
REQ-031 req0 and req1 high same cycle from reset, (3x-2) and (7x7) -> ack0 first with 8'hFA, then ack1 with 8'h31.
REQ-032 Both held high for 4 operations -> grants alternate 0,1,0,1; no double ack.
REQ-033 Model never raises Fin, req1 with 5x5 -> ack1 TIMEOUT+2 cycles after m_start, error=1, resultado=0.
REQ-034 rst asserted in ESPERA -> outputs at reset values same cycle, no ack; after release req1 (-1x-8) -> ack1, resultado=8'h08.
REQ-035 Exhaustive sweep -8..7 x -8..7 via req0 -> all 256 products match signed reference.
